// File: rtl/insight_dcache_resp_tracker.sv
// Pairs hart-0 DCache Insight request/response records by tag and emits completed accesses.
// Optional watchdog: define INSIGHT_DCACHE_TRACKER_TIMEOUT_EN to build the timeout_err comparators.
module insight_dcache_resp_tracker #(
  parameter int TAG_W      = 3,
  parameter int ADDR_W     = 40,
  parameter int TS_W       = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_W     = 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [4:0]        req_cmd,
  input  logic              resp_valid,
  input  logic [TAG_W-1:0]  resp_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [4:0]        out_cmd,
  output logic [TAG_W-1:0]  out_tag,
  output logic [TS_W-1:0]   out_latency,
  output logic [TAG_W:0]    outstanding,
  output logic              dup_err,
  output logic              orphan_err,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              timeout_err
);

  localparam int N  = 1 << TAG_W;
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [N-1:0]      live;
  logic [N-1:0]      live_n;
  logic [ADDR_W-1:0] e_addr [N];
  logic [4:0]        e_cmd  [N];
  logic [TS_W-1:0]   e_ts   [N];
  logic [TS_W-1:0]   ts;

  logic [ADDR_W-1:0] f_addr [FIFO_DEPTH];
  logic [4:0]        f_cmd  [FIFO_DEPTH];
  logic [TAG_W-1:0]  f_tag  [FIFO_DEPTH];
  logic [TS_W-1:0]   f_lat  [FIFO_DEPTH];
  logic [PW:0]       wr_ptr;
  logic [PW:0]       rd_ptr;
  logic [PW:0]       cnt;

  logic hit, orphan, same, dup, alloc;
  logic full, pop, push, drop;
  logic [TS_W-1:0] rec_lat;
  logic [TAG_W:0]  outstanding_n;

  assign hit     = resp_valid && live[resp_tag];
  assign orphan  = resp_valid && !live[resp_tag];
  assign same    = req_valid && resp_valid && (req_tag == resp_tag);
  // A same-tag response retires the old entry before the request lands.
  assign dup     = req_valid && live[req_tag] && !same;
  assign alloc   = req_valid && (!live[req_tag] || same);
  assign rec_lat = ts - e_ts[resp_tag];

  assign cnt       = wr_ptr - rd_ptr;
  assign full      = (cnt == (PW+1)'(FIFO_DEPTH));
  assign out_valid = (cnt != '0);
  assign pop       = out_valid && out_ready;
  assign push      = hit && (!full || pop);
  assign drop      = hit && full && !pop;

  assign outstanding_n = outstanding + (TAG_W+1)'(alloc)
                       - (TAG_W+1)'(hit);

  always_comb begin
    live_n = live;
    if (hit)
      live_n[resp_tag] = 1'b0;
    if (req_valid)
      live_n[req_tag] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      live        <= '0;
      ts          <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
      dup_err     <= 1'b0;
      orphan_err  <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      live        <= live_n;
      ts          <= ts + 1'b1;
      outstanding <= outstanding_n;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (dup)
        dup_err <= 1'b1;
      if (orphan)
        orphan_err <= 1'b1;
      if (drop && drop_cnt != '1)
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (req_valid) begin
      e_addr[req_tag] <= req_addr;
      e_cmd[req_tag]  <= req_cmd;
      e_ts[req_tag]   <= ts;
    end
    if (push) begin
      f_addr[wr_ptr[PW-1:0]] <= e_addr[resp_tag];
      f_cmd[wr_ptr[PW-1:0]]  <= e_cmd[resp_tag];
      f_tag[wr_ptr[PW-1:0]]  <= resp_tag;
      f_lat[wr_ptr[PW-1:0]]  <= rec_lat;
    end
  end

  assign out_addr    = out_valid ? f_addr[rd_ptr[PW-1:0]] : '0;
  assign out_cmd     = out_valid ? f_cmd[rd_ptr[PW-1:0]]  : '0;
  assign out_tag     = out_valid ? f_tag[rd_ptr[PW-1:0]]  : '0;
  assign out_latency = out_valid ? f_lat[rd_ptr[PW-1:0]]  : '0;

`ifdef INSIGHT_DCACHE_TRACKER_TIMEOUT_EN
  logic to_hit;

  always_comb begin
    to_hit = 1'b0;
    for (int i = 0; i < N; i++)
      if (live[i] && (ts - e_ts[i]) >= TS_W'(TIMEOUT))
        to_hit = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      timeout_err <= 1'b0;
    else if (to_hit)
      timeout_err <= 1'b1;
  end
`else
  // Watchdog not built; a non-negative threshold keeps this constant 0.
  assign timeout_err = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_insight_dcache_resp_tracker.sv
// Self-checking bench for insight_dcache_resp_tracker: directed steps plus random traffic
// against a tag-table / record-queue reference model.
module tb_insight_dcache_resp_tracker;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [2:0]  req_tag = '0;
  logic [39:0] req_addr = '0;
  logic [4:0]  req_cmd = '0;
  logic        resp_valid = 1'b0;
  logic [2:0]  resp_tag = '0;
  logic        out_ready = 1'b1;
  logic        out_valid;
  logic [39:0] out_addr;
  logic [4:0]  out_cmd;
  logic [2:0]  out_tag;
  logic [15:0] out_latency;
  logic [3:0]  outstanding;
  logic        dup_err;
  logic        orphan_err;
  logic [7:0]  drop_cnt;
  logic        timeout_err;

  insight_dcache_resp_tracker dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_tag(req_tag),
    .req_addr(req_addr), .req_cmd(req_cmd),
    .resp_valid(resp_valid), .resp_tag(resp_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_cmd(out_cmd),
    .out_tag(out_tag), .out_latency(out_latency),
    .outstanding(outstanding), .dup_err(dup_err),
    .orphan_err(orphan_err), .drop_cnt(drop_cnt),
    .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [39:0] addr;
    logic [4:0]  cmd;
    logic [2:0]  tag;
    logic [15:0] lat;
  } rec_t;

  bit          m_live [8];
  logic [39:0] m_addr [8];
  logic [4:0]  m_cmd  [8];
  int          m_req  [8];
  rec_t        m_q [$];
  int          m_cyc;
  int          m_drop;
  bit          m_dup;
  bit          m_orphan;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int live_count();
    int n = 0;
    for (int i = 0; i < 8; i++)
      n += int'(m_live[i]);
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++)
      m_live[i] = 1'b0;
    m_q.delete();
    m_cyc = 0;
    m_drop = 0;
    m_dup = 1'b0;
    m_orphan = 1'b0;
  endtask

  // Behaviour at one clock edge: pop, retire (pushing if room), then allocate.
  task automatic model_edge();
    rec_t r;
    if (m_q.size() > 0 && out_ready)
      void'(m_q.pop_front());
    if (resp_valid) begin
      if (m_live[resp_tag]) begin
        r.addr = m_addr[resp_tag];
        r.cmd  = m_cmd[resp_tag];
        r.tag  = resp_tag;
        r.lat  = 16'((m_cyc - m_req[resp_tag]) & 'hFFFF);
        m_live[resp_tag] = 1'b0;
        if (m_q.size() < 4)
          m_q.push_back(r);
        else
          m_drop++;
      end else
        m_orphan = 1'b1;
    end
    if (req_valid) begin
      if (m_live[req_tag])
        m_dup = 1'b1;
      m_live[req_tag] = 1'b1;
      m_addr[req_tag] = req_addr;
      m_cmd[req_tag]  = req_cmd;
      m_req[req_tag]  = m_cyc;
    end
    m_cyc++;
  endtask

  task automatic check_all();
    rec_t h;
    bit   ne = (m_q.size() > 0);
    h = '{addr: '0, cmd: '0, tag: '0, lat: '0};
    if (ne)
      h = m_q[0];
    chk("out_valid", 64'(out_valid), 64'(ne));
    chk("out_addr", 64'(out_addr), 64'(h.addr));
    chk("out_cmd", 64'(out_cmd), 64'(h.cmd));
    chk("out_tag", 64'(out_tag), 64'(h.tag));
    chk("out_latency", 64'(out_latency), 64'(h.lat));
    chk("outstanding", 64'(outstanding), 64'(live_count()));
    chk("dup_err", 64'(dup_err), 64'(m_dup));
    chk("orphan_err", 64'(orphan_err), 64'(m_orphan));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop > 255 ? 255 : m_drop));
    chk("timeout_err", 64'(timeout_err), 64'(0));
  endtask

  task automatic cycle(input bit rv, input logic [2:0] rt,
                       input logic [39:0] ra, input logic [4:0] rc,
                       input bit sv, input logic [2:0] st,
                       input bit ordy, input bit do_chk);
    req_valid  = rv;
    req_tag    = rt;
    req_addr   = ra;
    req_cmd    = rc;
    resp_valid = sv;
    resp_tag   = st;
    out_ready  = ordy;
    @(posedge clock);
    model_edge();
    #1;
    req_valid  = 1'b0;
    resp_valid = 1'b0;
    if (do_chk)
      check_all();
  endtask

  task automatic req(input logic [2:0] t, input logic [39:0] a,
                     input logic [4:0] c, input bit ordy);
    cycle(1'b1, t, a, c, 1'b0, 3'd0, ordy, 1'b1);
  endtask

  task automatic resp(input logic [2:0] t, input bit ordy);
    cycle(1'b0, 3'd0, 40'd0, 5'd0, 1'b1, t, ordy, 1'b1);
  endtask

  task automatic idle(input int n, input bit do_chk);
    for (int i = 0; i < n; i++)
      cycle(1'b0, 3'd0, 40'd0, 5'd0, 1'b0, 3'd0, 1'b1, do_chk);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_outstanding", 64'(outstanding), 64'(0));
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check_all();
  endtask

  initial begin
    model_reset();
    #2;
    check_all();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_all();

    // Basic pairing, latency 5
    idle(3, 1'b1);
    req(3'd2, 40'h0080001000, 5'd0, 1'b1);
    idle(4, 1'b1);
    resp(3'd2, 1'b1);
    chk("t1_valid", 64'(out_valid), 64'(1));
    chk("t1_addr", 64'(out_addr), 64'h80001000);
    chk("t1_tag", 64'(out_tag), 64'(2));
    chk("t1_lat", 64'(out_latency), 64'(5));
    chk("t1_outst", 64'(outstanding), 64'(0));
    idle(1, 1'b1);

    // Orphan and duplicate
    resp(3'd5, 1'b1);
    chk("t2_orphan", 64'(orphan_err), 64'(1));
    chk("t2_no_out", 64'(out_valid), 64'(0));
    req(3'd3, 40'h11, 5'd1, 1'b1);
    req(3'd3, 40'h22, 5'd2, 1'b1);
    chk("t2_dup", 64'(dup_err), 64'(1));
    chk("t2_outst", 64'(outstanding), 64'(1));
    resp(3'd3, 1'b1);
    chk("t2_addr", 64'(out_addr), 64'h22);
    idle(1, 1'b1);

    // FIFO full: 6 records, 4 held, 2 dropped
    pulse_reset();
    for (int i = 0; i < 6; i++)
      req(3'(i), 40'(64'h1000 + i), 5'(i), 1'b0);
    for (int i = 0; i < 6; i++)
      resp(3'(i), 1'b0);
    chk("t3_drop", 64'(drop_cnt), 64'(2));
    for (int i = 0; i < 4; i++) begin
      chk("t3_tag", 64'(out_tag), 64'(i));
      idle(1, 1'b1);
    end
    chk("t3_empty", 64'(out_valid), 64'(0));

    // Same-tag same-cycle request and response
    req(3'd1, 40'h0ABC, 5'd3, 1'b1);
    idle(2, 1'b1);
    cycle(1'b1, 3'd1, 40'h0DEF, 5'd4, 1'b1, 3'd1, 1'b1, 1'b1);
    chk("t4_addr", 64'(out_addr), 64'h0ABC);
    chk("t4_lat", 64'(out_latency), 64'(3));
    chk("t4_outst", 64'(outstanding), 64'(1));
    chk("t4_dup", 64'(dup_err), 64'(0));
    resp(3'd1, 1'b1);
    chk("t4_new", 64'(out_addr), 64'h0DEF);
    idle(1, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom), 3'($urandom), {8'($urandom), 32'($urandom)},
            5'($urandom), 1'($urandom), 3'($urandom),
            ($urandom % 4) != 0, 1'b1);
    idle(6, 1'b1);

    // Timestamp wrap; tag 7 held across the whole wrap
    pulse_reset();
    req(3'd7, 40'h77, 5'd7, 1'b1);
    idle(2000, 1'b0);
    check_all();
    while ((m_cyc & 'hFFFF) != 'hFFFE)
      idle(1, 1'b0);
    req(3'd6, 40'h66, 5'd6, 1'b1);
    idle(3, 1'b1);
    resp(3'd6, 1'b1);
    chk("t5_lat", 64'(out_latency), 64'(4));
    resp(3'd7, 1'b1);
    idle(1, 1'b1);

    // Reset mid-transaction: 3 live, 2 queued
    for (int i = 0; i < 5; i++)
      req(3'(i), 40'(i), 5'(i), 1'b0);
    resp(3'd3, 1'b0);
    resp(3'd4, 1'b0);
    chk("t6_queued", 64'(out_valid), 64'(1));
    chk("t6_live", 64'(outstanding), 64'(3));
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("t6_valid", 64'(out_valid), 64'(0));
    chk("t6_outst", 64'(outstanding), 64'(0));
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check_all();
    req(3'd0, 40'h5, 5'd5, 1'b1);
    resp(3'd0, 1'b1);
    chk("t6_lat", 64'(out_latency), 64'(1));
    idle(1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/insight_dcache_resp_tracker.md
Name: insight_dcache_resp_tracker

Overview:
- Consumer end of the hart-0 DCache Insight trace: receives per-commit dcache request records and their later response records, and pairs each response with its request by tag.
- Sits beside the hart trace sink. Emits one completed-access record per response (address, command, latency) through a valid/ready output buffer.
- Maintains sticky protocol-error flags and a dropped-record counter for debug.

Parameters:
- TAG_W, 3, request/response tag width; the tracker holds 2^TAG_W outstanding entries.
- ADDR_W, 40, request address width.
- TS_W, 16, free-running timestamp and latency width.
- FIFO_DEPTH, 4, output record buffer depth (power of 2, ≥2).
- DROP_W, 8, dropped-record counter width.
- TIMEOUT, 1024, watchdog threshold in cycles (optional feature only).

Ports:
- clock  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request record valid this cycle (no backpressure).
- req_tag  in  TAG_W  request tag.
- req_addr  in  ADDR_W  request address.
- req_cmd  in  5  memory command code.
- resp_valid  in  1  response record valid this cycle (no backpressure).
- resp_tag  in  TAG_W  tag of the request being answered.
- out_valid  out  1  completed record available.
- out_ready  in  1  consumer accepts the record.
- out_addr  out  ADDR_W  address of the completed request.
- out_cmd  out  5  command of the completed request.
- out_tag  out  TAG_W  tag of the completed request.
- out_latency  out  TS_W  response cycle minus request cycle, modulo 2^TS_W.
- outstanding  out  TAG_W+1  count of live entries.
- dup_err  out  1  sticky: a request arrived on a tag that was already live.
- orphan_err  out  1  sticky: a response arrived on a tag that was not live.
- drop_cnt  out  DROP_W  saturating count of records lost to a full buffer.
- timeout_err  out  1  sticky watchdog flag; tied to 0 when the feature is off.

Behaviour:
- Reset, all values 0: entry valid bits, timestamp counter, FIFO pointers, out_valid, outstanding, all error flags, drop_cnt. Record payload outputs are 0 when the FIFO is empty.
- Timestamp counter: increments every cycle and wraps at 2^TS_W.
- Request handling: on req_valid, entry[req_tag] captures {addr, cmd, ts} and valid is set.
  - If the entry was already live, dup_err is set and the entry is overwritten with the new request.
- Response handling: on resp_valid, if entry[resp_tag] is live, the record {addr, cmd, tag, latency} is built and valid is cleared.
  - latency = ts_now − entry.ts, truncated to TS_W. A same-cycle-next response gives latency 1.
  - If the entry is not live, orphan_err is set and nothing is pushed.
- Same tag, same cycle, req and resp: the response retires the old entry first (record pushed), then the request allocates the entry. dup_err is not set.
- Different tags, same cycle: both events are processed independently.
- Response latency: the record is pushed into the FIFO at the clock edge of resp_valid. out_valid rises the following cycle, so minimum latency is 1 cycle.
- FIFO handshake: a pop occurs when out_valid && out_ready. The output payload is the FIFO head, registered, and holds stable while out_valid && !out_ready.
- FIFO full: a push into a full FIFO is discarded. The entry is still retired and drop_cnt increments, saturating at all-ones.
  - A simultaneous pop and push when full is accepted with no drop.
- outstanding: +1 on allocation, −1 on retirement, net 0 on the same-tag same-cycle case.
  - Overwrite on a dup leaves the count unchanged.
- Sticky flags clear only on reset.
- Reset asserted mid-transaction: all entries and queued records are discarded immediately, asynchronously.

Optional Feature:
- Macro INSIGHT_DCACHE_TRACKER_TIMEOUT_EN.
- When defined: each cycle, every live entry with (ts_now − entry.ts) ≥ TIMEOUT sets timeout_err (sticky). The entry stays live and still pairs normally if a response comes later.
- When undefined: the comparators are not built and timeout_err is constant 0.

Test Plan:
- Tag 2 req addr 0x80001000 cmd 0 at cycle 10, resp tag 2 at cycle 15, out_ready=1 → out_valid at cycle 16 with addr 0x80001000, tag 2, latency 5; outstanding returns 0.
- Response on idle tag 5 → orphan_err=1, no out_valid, outstanding unchanged; a second req on live tag 3 → dup_err=1, outstanding stays 1.
- out_ready=0, 6 reqs then 6 resps on tags 0-5, FIFO_DEPTH=4 → 4 records held in order tags 0-3, drop_cnt=2; releasing out_ready drains tags 0-3.
- Same-cycle req+resp on live tag 1 → old record emitted, new entry live, outstanding unchanged, dup_err=0.
- Req at ts 0xFFFE, resp 4 cycles later → latency 4 across the wrap. Assert reset with 3 entries live and 2 records queued → out_valid=0, outstanding=0 immediately.
- Feature on, TIMEOUT=1024: hold a req 1024 cycles → timeout_err=1 at cycle 1024, the later response still emits latency ≥1024 mod 2^16. Feature off → timeout_err stays 0.
